// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Brief    : Line-based instruction fetch queue. Accepts 128-bit I-cache lines,
//            owns the fetch PC and hands one 32-bit instruction per cycle with
//            its PC to the decoder. A redirect (flush) empties the queue and
//            restarts fetch at the target word.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    output logic [31:0]  fetch_pc,
    input  logic         line_valid,
    input  logic [127:0] line_data,
    output logic         line_ready,
    output logic         instr_valid,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc,
    output logic [31:0]  instr_pc_plus4,
    input  logic         dispatch_ready,
    input  logic         flush,
    input  logic [31:0]  flush_pc
);

    localparam int                 c_IDX_W   = $clog2(DEPTH);
    localparam logic [c_IDX_W:0]   c_PTR_ONE = {{c_IDX_W{1'b0}}, 1'b1};

    // Line storage: data and the line-aligned PC it was fetched from
    logic [127:0]       r_line_data [DEPTH];
    logic [31:0]        r_line_pc   [DEPTH];

    // Pointers carry one extra MSB so full and empty can be told apart
    logic [c_IDX_W:0]   r_wr_ptr;
    logic [c_IDX_W:0]   r_rd_ptr;
    logic [1:0]         r_word_sel;
    logic [31:0]        r_fetch_pc;

    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_retire;
    logic [127:0]       w_head_data;
    logic [31:0]        w_head_pc;
    logic               w_unused;

    assign w_wr_idx = r_wr_ptr[c_IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[c_IDX_W-1:0];
    assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);

    // Flush blanks both handshakes in its own cycle
    assign line_ready  = !w_full && !flush;
    assign instr_valid = !w_empty && !flush;

    assign w_push   = line_valid && line_ready;
    assign w_pop    = instr_valid && dispatch_ready;
    assign w_retire = w_pop && (r_word_sel == 2'd3);

    assign w_head_data    = r_line_data[w_rd_idx];
    assign w_head_pc      = r_line_pc[w_rd_idx];
    assign instr          = w_head_data[{r_word_sel, 5'b0_0000} +: 32];
    assign instr_pc       = w_head_pc + {28'd0, r_word_sel, 2'b00};
    assign instr_pc_plus4 = instr_pc + 32'd4;
    assign fetch_pc       = r_fetch_pc;

    // Word-alignment bits of the redirect target carry no information
    assign w_unused = ^flush_pc[1:0];

    // Line storage write; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_line_data[w_wr_idx] <= line_data;
            r_line_pc[w_wr_idx]   <= r_fetch_pc;
        end
    end

    // Pointer, word selector and fetch PC update; reset beats flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_word_sel <= 2'd0;
            r_fetch_pc <= RESET_PC;
        end else if (flush) begin
            // Empty the queue and park word_sel on the target word so the
            // first line fetched after the redirect starts there
            r_rd_ptr   <= r_wr_ptr;
            r_word_sel <= flush_pc[3:2];
            r_fetch_pc <= {flush_pc[31:4], 4'b0000};
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
                r_fetch_pc <= r_fetch_pc + 32'd16;
            end
            if (w_retire) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_word_sel <= 2'd0;
            end else if (w_pop) begin
                r_word_sel <= r_word_sel + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Brief    : Self-checking bench for instr_fetch_queue. Two instances (default
//            reset PC and a reset PC just below the 4 GiB wrap) share one
//            directed stimulus stream and are checked every cycle against an
//            instruction-level queue model, plus literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         line_valid = 1'b0;
    logic [127:0] line_data = '0;
    logic         dispatch_ready = 1'b0;
    logic         flush = 1'b0;
    logic [31:0]  flush_pc = '0;

    logic [31:0]  fpc0, instr0, ipc0, ipc40;
    logic [31:0]  fpc1, instr1, ipc1, ipc41;
    logic         lr0, iv0, lr1, iv1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .fetch_pc(fpc0), .line_valid(line_valid),
        .line_data(line_data), .line_ready(lr0), .instr_valid(iv0),
        .instr(instr0), .instr_pc(ipc0), .instr_pc_plus4(ipc40),
        .dispatch_ready(dispatch_ready), .flush(flush), .flush_pc(flush_pc)
    );

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_dut_wrap (
        .clk(clk), .rst(rst), .fetch_pc(fpc1), .line_valid(line_valid),
        .line_data(line_data), .line_ready(lr1), .instr_valid(iv1),
        .instr(instr1), .instr_pc(ipc1), .instr_pc_plus4(ipc41),
        .dispatch_ready(dispatch_ready), .flush(flush), .flush_pc(flush_pc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Recognisable word w of line n
    function automatic logic [31:0] word_of(input int n, input int w);
        return 32'hA000_0000 | (32'(n) << 8) | 32'(w);
    endfunction

    function automatic logic [127:0] mkline(input int n);
        return {word_of(n, 3), word_of(n, 2), word_of(n, 1), word_of(n, 0)};
    endfunction

    // ---------------- reference model: queue of individual instructions -----
    logic [31:0] m_w   [2][64];
    logic [31:0] m_p   [2][64];
    int          m_head[2];
    int          m_cnt [2];
    logic [31:0] m_fpc [2];
    int          m_start[2];

    logic        a_lr, a_iv, e_lr, e_iv;
    logic [31:0] a_fpc, a_instr, a_pc, a_pc4;
    int          lines, idx;

    // Compare both DUTs to the model each cycle, then advance the model to
    // the state it must hold after the coming rising edge
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            a_lr    = (k == 0) ? lr0    : lr1;
            a_iv    = (k == 0) ? iv0    : iv1;
            a_fpc   = (k == 0) ? fpc0   : fpc1;
            a_instr = (k == 0) ? instr0 : instr1;
            a_pc    = (k == 0) ? ipc0   : ipc1;
            a_pc4   = (k == 0) ? ipc40  : ipc41;
            if (rst) begin
                m_head[k]  = 0;
                m_cnt[k]   = 0;
                m_start[k] = 0;
                m_fpc[k]   = (k == 0) ? 32'h0 : WRAP_PC;
            end else begin
                // Every buffered line still holds its word 3 until it retires
                lines = 0;
                for (int i = 0; i < m_cnt[k]; i++)
                    if (m_p[k][(m_head[k] + i) % 64][3:2] == 2'd3) lines++;
                e_lr = (lines < DEPTH) && !flush;
                e_iv = (m_cnt[k] > 0) && !flush;
                chk($sformatf("model fetch_pc[%0d]", k), a_fpc, m_fpc[k]);
                chk($sformatf("model line_ready[%0d]", k), {31'd0, a_lr}, {31'd0, e_lr});
                chk($sformatf("model instr_valid[%0d]", k), {31'd0, a_iv}, {31'd0, e_iv});
                if (e_iv) begin
                    chk($sformatf("model instr[%0d]", k), a_instr, m_w[k][m_head[k]]);
                    chk($sformatf("model instr_pc[%0d]", k), a_pc, m_p[k][m_head[k]]);
                    chk($sformatf("model instr_pc_plus4[%0d]", k), a_pc4, m_p[k][m_head[k]] + 32'd4);
                end
                if (flush) begin
                    m_cnt[k]   = 0;
                    m_fpc[k]   = {flush_pc[31:4], 4'b0000};
                    m_start[k] = int'(flush_pc[3:2]);
                end else begin
                    if (e_iv && dispatch_ready) begin
                        m_head[k] = (m_head[k] + 1) % 64;
                        m_cnt[k]  = m_cnt[k] - 1;
                    end
                    if (line_valid && e_lr) begin
                        for (int w = m_start[k]; w < 4; w++) begin
                            idx = (m_head[k] + m_cnt[k]) % 64;
                            m_w[k][idx] = line_data[w*32 +: 32];
                            m_p[k][idx] = m_fpc[k] + 32'(4 * w);
                            m_cnt[k]    = m_cnt[k] + 1;
                        end
                        m_fpc[k]   = m_fpc[k] + 32'd16;
                        m_start[k] = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic cyc(input logic lv, input logic [127:0] ld, input logic dr,
                       input logic fl, input logic [31:0] fp);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        line_valid     = lv;
        line_data      = ld;
        dispatch_ready = dr;
        flush          = fl;
        flush_pc       = fp;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        line_valid     = 1'b0;
        dispatch_ready = 1'b0;
        flush          = 1'b0;
    endtask

    int n;
    int first_extra;

    initial begin
        repeat (2) @(posedge clk);

        // Single line streams out over four cycles
        cyc(1'b1, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b1, 1'b0, 32'h0);
        #2;
        chk("reset fetch_pc", fpc0, 32'h0);
        chk("reset fetch_pc wrap", fpc1, WRAP_PC);
        chk("reset instr_valid", {31'd0, iv0}, 32'd0);
        chk("reset line_ready", {31'd0, lr0}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
            #2;
            chk("p1 instr", instr0, 32'(i + 1));
            chk("p1 instr_pc", ipc0, 32'(4 * i));
            chk("p1 instr_pc_plus4", ipc40, 32'(4 * i + 4));
            if (i == 0) chk("p1 fetch_pc", fpc0, 32'h10);
        end
        cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
        #2;
        chk("p1 drained", {31'd0, iv0}, 32'd0);

        // Fill to full with the decoder stalled, then drain
        do_reset();
        n = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(1'b1, mkline(n), 1'b0, 1'b0, 32'h0);
            #2;
            if (lr0) n++;
        end
        chk("full line_ready", {31'd0, lr0}, 32'd0);
        chk("full fetch_pc", fpc0, 32'h40);
        chk("full accepts", 32'(n), 32'd4);
        first_extra = -1;
        for (int c = 0; c < 21; c++) begin
            cyc(n < 5, mkline(n), 1'b1, 1'b0, 32'h0);
            #2;
            if (c < 16) begin
                chk("drain valid", {31'd0, iv0}, 32'd1);
                chk("drain instr", instr0, word_of(c / 4, c % 4));
            end
            if (lr0 && line_valid) begin
                if (first_extra < 0) first_extra = c;
                n++;
            end
        end
        chk("extra accept cycle", 32'(first_extra), 32'd4);
        chk("total accepts", 32'(n), 32'd5);
        chk("drain fetch_pc", fpc0, 32'h50);

        // Flush with three lines buffered, restart mid-line
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, mkline(10 + i), 1'b0, 1'b0, 32'h0);
        cyc(1'b0, '0, 1'b1, 1'b1, 32'h0000_0128);
        #2;
        chk("flush line_ready", {31'd0, lr0}, 32'd0);
        chk("flush instr_valid", {31'd0, iv0}, 32'd0);
        cyc(1'b1, {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, 1'b1, 1'b0, 32'h0);
        #2;
        chk("post-flush valid", {31'd0, iv0}, 32'd0);
        chk("post-flush fetch_pc", fpc0, 32'h120);
        chk("post-flush fetch_pc wrap", fpc1, 32'h120);
        cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
        #2;
        chk("target instr", instr0, 32'hCCCC_0002);
        chk("target pc", ipc0, 32'h128);
        chk("target pc4", ipc40, 32'h12C);
        cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
        #2;
        chk("target+1 instr", instr0, 32'hDDDD_0003);
        chk("target+1 pc", ipc0, 32'h12C);
        cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
        #2;
        chk("after target empty", {31'd0, iv0}, 32'd0);

        // Line offered in the flush cycle is dropped
        cyc(1'b1, mkline(20), 1'b1, 1'b1, 32'h0000_0200);
        #2;
        chk("flush+line ready", {31'd0, lr0}, 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
        #2;
        chk("flush+line fetch_pc", fpc0, 32'h200);
        chk("flush+line valid", {31'd0, iv0}, 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
        #2;
        chk("flush+line dropped", {31'd0, iv0}, 32'd0);

        // PC wrap across 2^32 on the high reset-PC instance
        do_reset();
        cyc(1'b1, mkline(30), 1'b0, 1'b0, 32'h0);
        cyc(1'b1, mkline(31), 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
            #2;
            if (i == 0) chk("wrap fetch_pc", fpc1, 32'h10);
            chk("wrap instr_pc", ipc1, WRAP_PC + 32'(4 * i));
            chk("wrap instr", instr1, word_of(30 + i / 4, i % 4));
        end

        // Random traffic with a mid-stream reset
        for (int c = 0; c < 200; c++) begin
            if (c == 100) begin
                do_reset();
                cyc(1'b0, '0, 1'b0, 1'b0, 32'h0);
                #2;
                chk("midreset valid", {31'd0, iv0}, 32'd0);
                chk("midreset line_ready", {31'd0, lr0}, 32'd1);
                chk("midreset fetch_pc", fpc0, 32'h0);
                chk("midreset fetch_pc wrap", fpc1, WRAP_PC);
                chk("midreset valid wrap", {31'd0, iv1}, 32'd0);
            end else begin
                cyc(1'($urandom_range(0, 1)),
                    {$urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 15) == 0),
                    $urandom);
            end
        end

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
